// File: rtl/piso_serializer_4bit_pkg.sv
// Shared types and constants for the PISO word serializer.
// State encodings match the shift-register family.
package piso_serializer_4bit_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int GAP_CW        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Up-counter with synchronous clear and terminal-count flag.
// Used for both the bit count and the inter-word gap count.
module piso_bit_counter
  import piso_serializer_4bit_pkg::*;
#(
  parameter int W    = GAP_CW,
  parameter int TERM = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL = W'(TERM);

  logic [W-1:0] count;

  // count up when enabled; clear restarts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/piso_serializer_4bit.sv
// Parallel-in serial-out word serializer with ready/valid load.
// Out/Frame/Done are registered; Done marks the last bit.
module piso_serializer_4bit
  import piso_serializer_4bit_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0,
  parameter int GAP       = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             Load_valid,
  output logic             Load_ready,
  output logic             Out,
  output logic             Frame,
  output logic             Done
);

  localparam int BCW   = $clog2(WIDTH);
  localparam int GTERM = (GAP > 0) ? GAP - 1 : 0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             out_d, frame_d, done_d;
  logic             bclr, ben, btc;
  logic             gclr, gap_en, gtc;
  logic             accept, last;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // btc flags that the bit now on Out is the second to last
  piso_bit_counter #(
    .W    (BCW),
    .TERM (WIDTH - 2)
  ) u_bitcnt (
    .clk (Clock),
    .rst (Reset),
    .clr (bclr),
    .en  (ben),
    .tc  (btc)
  );

  piso_bit_counter #(
    .W    (GAP_CW),
    .TERM (GTERM)
  ) u_gapcnt (
    .clk (Clock),
    .rst (Reset),
    .clr (gclr),
    .en  (gap_en),
    .tc  (gtc)
  );

  // Done is high exactly while the last bit is on Out
  assign last = (state_q == ST_SHIFT) && Done;

  assign Load_ready = !Reset &&
                      ((state_q == ST_IDLE) ||
                       (last && (GAP == 0)));

  assign accept = Load_valid && Load_ready;

  // next state, next buffer and next registered outputs
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    out_d   = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;
    bclr    = 1'b0;
    ben     = 1'b0;
    gclr    = 1'b0;
    gap_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          out_d   = head(Data);
          sreg_d  = adv(Data);
          frame_d = 1'b1;
          bclr    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!last) begin
          out_d   = head(sreg_q);
          sreg_d  = adv(sreg_q);
          frame_d = 1'b1;
          done_d  = btc;
          ben     = 1'b1;
        end else if (GAP != 0) begin
          state_d = ST_GAP;
          gclr    = 1'b1;
        end else if (accept) begin
          out_d   = head(Data);
          sreg_d  = adv(Data);
          frame_d = 1'b1;
          bclr    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (gtc) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, buffer and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      Out     <= 1'b0;
      Frame   <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      Out     <= out_d;
      Frame   <= frame_d;
      Done    <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer_4bit.sv
// Directed self-checking bench for piso_serializer_4bit.
// Three instances: default, LSB-first, and GAP=2.
module tb_piso_serializer_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] m_d, l_d, g_d;
  logic       m_lv, l_lv, g_lv;
  logic       m_lr, l_lr, g_lr;
  logic       m_o, l_o, g_o;
  logic       m_f, l_f, g_f;
  logic       m_dn, l_dn, g_dn;
  logic [3:0] sipo;

  int checks;
  int errors;

  piso_serializer_4bit dut (
    .Clock      (clk),
    .Reset      (rst),
    .Data       (m_d),
    .Load_valid (m_lv),
    .Load_ready (m_lr),
    .Out        (m_o),
    .Frame      (m_f),
    .Done       (m_dn)
  );

  piso_serializer_4bit #(.LSB_FIRST(1'b1)) dut_l (
    .Clock      (clk),
    .Reset      (rst),
    .Data       (l_d),
    .Load_valid (l_lv),
    .Load_ready (l_lr),
    .Out        (l_o),
    .Frame      (l_f),
    .Done       (l_dn)
  );

  piso_serializer_4bit #(.GAP(2)) dut_g (
    .Clock      (clk),
    .Reset      (rst),
    .Data       (g_d),
    .Load_valid (g_lv),
    .Load_ready (g_lr),
    .Out        (g_o),
    .Frame      (g_f),
    .Done       (g_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream serial-in register fed by the main instance
  always @(posedge clk) begin
    if (rst) sipo <= 4'b0000;
    else if (m_f) sipo <= {sipo[2:0], m_o};
  end

  task automatic test_reset;
    rst = 1'b1;
    m_lv = 1'b0; l_lv = 1'b0; g_lv = 1'b0;
    m_d = 4'h0; l_d = 4'h0; g_d = 4'h0;
    repeat (2) @(negedge clk);
    m_lv = 1'b1;
    m_d = 4'hF;
    @(negedge clk);
    checks++;
    if ({m_o, m_f, m_dn, m_lr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold got o/f/d/r=%b want 0000",
               {m_o, m_f, m_dn, m_lr});
    end
    checks++;
    if ({l_o, l_f, l_dn, l_lr, g_o, g_f, g_dn, g_lr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_others got %b want 00000000",
               {l_o, l_f, l_dn, l_lr, g_o, g_f, g_dn, g_lr});
    end
    rst = 1'b0;
    m_lv = 1'b0;
    #1;
    checks++;
    if (m_lr !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", m_lr);
    end
    @(negedge clk);
    checks++;
    if ({m_o, m_f, m_dn} !== 3'b000) begin
      errors++;
      $display("FAIL reset_noload got o/f/d=%b want 000",
               {m_o, m_f, m_dn});
    end
  endtask

  task automatic test_single;
    logic [3:0] w;
    logic eo, ed;
    w = 4'b1011;
    @(negedge clk);
    m_d = w; m_lv = 1'b1;
    @(negedge clk);
    m_lv = 1'b0; m_d = 4'h0;
    for (int i = 0; i < 4; i++) begin
      eo = w[3-i];
      ed = (i == 3);
      checks++;
      if ({m_o, m_f, m_dn, m_lr} !== {eo, 1'b1, ed, ed}) begin
        errors++;
        $display("FAIL single_bit%0d got o/f/d/r=%b want %b", i,
                 {m_o, m_f, m_dn, m_lr}, {eo, 1'b1, ed, ed});
      end
      @(negedge clk);
    end
    checks++;
    if ({m_o, m_f, m_dn, m_lr} !== 4'b0001) begin
      errors++;
      $display("FAIL single_after got o/f/d/r=%b want 0001",
               {m_o, m_f, m_dn, m_lr});
    end
    checks++;
    if (sipo !== 4'b1011) begin
      errors++;
      $display("FAIL single_sipo got %b want 1011", sipo);
    end
  endtask

  task automatic test_lsb;
    logic [3:0] w;
    logic eo, ed;
    w = 4'b0001;
    @(negedge clk);
    l_d = w; l_lv = 1'b1;
    @(negedge clk);
    l_lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eo = w[i];
      ed = (i == 3);
      checks++;
      if ({l_o, l_f, l_dn, l_lr} !== {eo, 1'b1, ed, ed}) begin
        errors++;
        $display("FAIL lsb_bit%0d got o/f/d/r=%b want %b", i,
                 {l_o, l_f, l_dn, l_lr}, {eo, 1'b1, ed, ed});
      end
      @(negedge clk);
    end
    checks++;
    if ({l_o, l_f, l_dn} !== 3'b000) begin
      errors++;
      $display("FAIL lsb_after got o/f/d=%b want 000",
               {l_o, l_f, l_dn});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] s;
    logic eo, ed;
    s = 8'hA5;
    @(negedge clk);
    m_d = 4'hA; m_lv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      eo = s[7-i];
      ed = (i == 3) || (i == 7);
      checks++;
      if ({m_o, m_f, m_dn, m_lr} !== {eo, 1'b1, ed, ed}) begin
        errors++;
        $display("FAIL b2b_bit%0d got o/f/d/r=%b want %b", i,
                 {m_o, m_f, m_dn, m_lr}, {eo, 1'b1, ed, ed});
      end
      if (i == 0) m_d = 4'h5;
      if (i == 7) m_lv = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({m_o, m_f, m_dn, m_lr} !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_after got o/f/d/r=%b want 0001",
               {m_o, m_f, m_dn, m_lr});
    end
  endtask

  task automatic test_gap;
    logic [3:0] w1, w2;
    logic eo, ef, ed, er;
    w1 = 4'hC;
    w2 = 4'h3;
    @(negedge clk);
    g_d = w1; g_lv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      eo = 1'b0; ef = 1'b0; ed = 1'b0; er = 1'b0;
      if (i < 4) begin
        eo = w1[3-i]; ef = 1'b1; ed = (i == 3);
      end else if (i == 6 || i == 13) begin
        er = 1'b1;
      end else if (i >= 7 && i <= 10) begin
        eo = w2[10-i]; ef = 1'b1; ed = (i == 10);
      end
      checks++;
      if ({g_o, g_f, g_dn, g_lr} !== {eo, ef, ed, er}) begin
        errors++;
        $display("FAIL gap_cyc%0d got o/f/d/r=%b want %b", i,
                 {g_o, g_f, g_dn, g_lr}, {eo, ef, ed, er});
      end
      if (i == 0) g_d = w2;
      if (i == 7) g_lv = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_data_hold;
    logic [3:0] w;
    logic eo, ed;
    w = 4'h6;
    @(negedge clk);
    m_d = w; m_lv = 1'b1;
    @(negedge clk);
    m_lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_d = 4'($urandom);
      eo = w[3-i];
      ed = (i == 3);
      checks++;
      if ({m_o, m_f, m_dn} !== {eo, 1'b1, ed}) begin
        errors++;
        $display("FAIL hold_bit%0d got o/f/d=%b want %b", i,
                 {m_o, m_f, m_dn}, {eo, 1'b1, ed});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] w;
    logic eo, ed;
    @(negedge clk);
    m_d = 4'hF; m_lv = 1'b1;
    @(negedge clk);
    m_lv = 1'b0;
    checks++;
    if ({m_o, m_f, m_dn} !== 3'b110) begin
      errors++;
      $display("FAIL rmid_bit0 got o/f/d=%b want 110",
               {m_o, m_f, m_dn});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_o, m_f, m_dn, m_lr} !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_abort got o/f/d/r=%b want 0000",
               {m_o, m_f, m_dn, m_lr});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m_lr !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ready got %b want 1", m_lr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({m_o, m_f, m_dn} !== 3'b000) begin
        errors++;
        $display("FAIL rmid_quiet%0d got o/f/d=%b want 000", i,
                 {m_o, m_f, m_dn});
      end
    end
    w = 4'h3;
    m_d = w; m_lv = 1'b1;
    @(negedge clk);
    m_lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eo = w[3-i];
      ed = (i == 3);
      checks++;
      if ({m_o, m_f, m_dn} !== {eo, 1'b1, ed}) begin
        errors++;
        $display("FAIL rmid_new%0d got o/f/d=%b want %b", i,
                 {m_o, m_f, m_dn}, {eo, 1'b1, ed});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_lsb();
    test_back_to_back();
    test_gap();
    test_data_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
